// File: rtl/rf_pkg.sv
// Shared register-file types: widths of the 4x16 register file and the
// {addr, data} write-request bundle used by queue entries and the RF write port.
package rf_pkg;

    localparam int RF_ADDR_W   = 2;
    localparam int RF_DATA_W   = 16;
    localparam int RF_NUM_REGS = 4;

    typedef struct packed {
        logic [RF_ADDR_W-1:0] addr;
        logic [RF_DATA_W-1:0] data;
    } rf_wr_req_t;

endpackage

// File: rtl/rf_write_queue_if.sv
// Request, register-file write and forwarding signals of the write queue.
// The slave modport is the queue; the master modport is its environment.
interface rf_write_queue_if
    import rf_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int DATA_W = RF_DATA_W,
    localparam int CNT_W = $clog2(DEPTH) + 1
) ();

    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_addr;
    logic [DATA_W-1:0] in_data;

    logic              drain_en;
    logic              rf_write;
    logic [ADDR_W-1:0] rf_addr3;
    logic [DATA_W-1:0] rf_data3;

    logic [ADDR_W-1:0] fwd_addr1;
    logic [ADDR_W-1:0] fwd_addr2;
    logic              fwd_hit1;
    logic [DATA_W-1:0] fwd_data1;
    logic              fwd_hit2;
    logic [DATA_W-1:0] fwd_data2;

    logic [CNT_W-1:0]  count;
    logic              empty;
    logic              full;

    modport slave (
        input  in_valid, in_addr, in_data, drain_en, fwd_addr1, fwd_addr2,
        output in_ready, rf_write, rf_addr3, rf_data3,
               fwd_hit1, fwd_data1, fwd_hit2, fwd_data2, count, empty, full
    );

    modport master (
        output in_valid, in_addr, in_data, drain_en, fwd_addr1, fwd_addr2,
        input  in_ready, rf_write, rf_addr3, rf_data3,
               fwd_hit1, fwd_data1, fwd_hit2, fwd_data2, count, empty, full
    );

endinterface

// File: rtl/rf_fwd_match.sv
// Newest-first search of the occupied queue entries for one read address;
// returns the value of the youngest pending write to that register.
module rf_fwd_match
    import rf_pkg::*;
#(
    parameter int DEPTH  = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  rf_wr_req_t           entries_i [DEPTH],
    input  logic [PTR_W-1:0]     head_i,
    input  logic [CNT_W-1:0]     count_i,
    input  logic [RF_ADDR_W-1:0] addr_i,
    output logic                 hit_o,
    output logic [RF_DATA_W-1:0] data_o
);

    // NOTE: every output gets a default before the loop so no latch is inferred.
    // Walking oldest to newest lets a younger match overwrite an older one.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) < count_i &&
                entries_i[head_i + PTR_W'(i)].addr == addr_i) begin
                hit_o  = 1'b1;
                data_o = entries_i[head_i + PTR_W'(i)].data;
            end
        end
    end

endmodule

// File: rtl/rf_write_queue.sv
// Circular FIFO of pending register-file writes: drains one entry per cycle into
// the RF write port and forwards the newest pending value on both read addresses.
module rf_write_queue
    import rf_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int DATA_W = RF_DATA_W
) (
    input  logic          clk,
    input  logic          reset,
    rf_write_queue_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    rf_wr_req_t       entries_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full, empty, enq, deq;

    always_comb begin
        full    = (count_q == CNT_W'(DEPTH));
        empty   = (count_q == '0);
        enq     = bus.in_valid && !full;
        deq     = bus.drain_en && !empty;
        head_d  = deq ? head_q + PTR_W'(1) : head_q;
        tail_d  = enq ? tail_q + PTR_W'(1) : tail_q;
        count_d = count_q;
        unique case ({enq, deq})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values computed above.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            // NOTE: the entry array is cleared on reset so stale data can never
            // appear on rf_addr3/rf_data3 or the forwarding outputs.
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (enq) begin
                entries_q[tail_q] <= '{addr: bus.in_addr, data: bus.in_data};
            end
        end
    end

    assign bus.in_ready = !full;
    assign bus.rf_write = deq;
    assign bus.rf_addr3 = empty ? ADDR_W'(0) : entries_q[head_q].addr;
    assign bus.rf_data3 = empty ? DATA_W'(0) : entries_q[head_q].data;
    assign bus.count    = count_q;
    assign bus.empty    = empty;
    assign bus.full     = full;

    // A write enqueued this cycle is not yet in entries_q, so it is not forwarded.
    rf_fwd_match #(.DEPTH(DEPTH)) u_fwd1 (
        .entries_i (entries_q),
        .head_i    (head_q),
        .count_i   (count_q),
        .addr_i    (bus.fwd_addr1),
        .hit_o     (bus.fwd_hit1),
        .data_o    (bus.fwd_data1)
    );

    rf_fwd_match #(.DEPTH(DEPTH)) u_fwd2 (
        .entries_i (entries_q),
        .head_i    (head_q),
        .count_i   (count_q),
        .addr_i    (bus.fwd_addr2),
        .hit_o     (bus.fwd_hit2),
        .data_o    (bus.fwd_data2)
    );

endmodule

// File: tb/tb_rf_write_queue.sv
// Directed bench for rf_write_queue: table of per-cycle vectors for fill/drain
// plus hand-written sequences for reset, latency, wrap-around and forwarding.
module tb_rf_write_queue;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    logic [15:0] rf_model [4];

    rf_write_queue_if bus ();

    rf_write_queue dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.rf_write) rf_model[bus.rf_addr3] <= bus.rf_data3;
    end

    typedef struct {
        logic        v;
        logic [1:0]  a;
        logic [15:0] d;
        logic        dr;
        logic [1:0]  f1;
        logic [1:0]  f2;
        logic [2:0]  cnt;
        logic        rfw;
        logic [1:0]  rfa;
        logic [15:0] rfd;
        logic        h1;
        logic [15:0] d1;
        logic        h2;
        logic [15:0] d2;
        logic        rdy;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int r = 0; r < 4; r++) rf_model[r] = '0;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_addr   = '0;
        bus.in_data   = '0;
        bus.drain_en  = 1'b0;
        bus.fwd_addr1 = '0;
        bus.fwd_addr2 = '0;

        // fill with drain off (5th request rejected), then drain four in order
        vecs[0]  = '{1'b1, 2'd1, 16'h0001, 1'b0, 2'd1, 2'd2, 3'd0, 1'b0, 2'd0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1};
        vecs[1]  = '{1'b1, 2'd3, 16'h0003, 1'b0, 2'd1, 2'd2, 3'd1, 1'b0, 2'd1, 16'h0001, 1'b1, 16'h0001, 1'b0, 16'h0000, 1'b1};
        vecs[2]  = '{1'b1, 2'd1, 16'h0011, 1'b0, 2'd1, 2'd2, 3'd2, 1'b0, 2'd1, 16'h0001, 1'b1, 16'h0001, 1'b0, 16'h0000, 1'b1};
        vecs[3]  = '{1'b1, 2'd0, 16'h0000, 1'b0, 2'd1, 2'd2, 3'd3, 1'b0, 2'd1, 16'h0001, 1'b1, 16'h0011, 1'b0, 16'h0000, 1'b1};
        vecs[4]  = '{1'b1, 2'd2, 16'h5555, 1'b0, 2'd1, 2'd2, 3'd4, 1'b0, 2'd1, 16'h0001, 1'b1, 16'h0011, 1'b0, 16'h0000, 1'b0};
        vecs[5]  = '{1'b0, 2'd0, 16'h0000, 1'b0, 2'd1, 2'd2, 3'd4, 1'b0, 2'd1, 16'h0001, 1'b1, 16'h0011, 1'b0, 16'h0000, 1'b0};
        vecs[6]  = '{1'b0, 2'd0, 16'h0000, 1'b1, 2'd1, 2'd3, 3'd4, 1'b1, 2'd1, 16'h0001, 1'b1, 16'h0011, 1'b1, 16'h0003, 1'b0};
        vecs[7]  = '{1'b0, 2'd0, 16'h0000, 1'b1, 2'd1, 2'd3, 3'd3, 1'b1, 2'd3, 16'h0003, 1'b1, 16'h0011, 1'b1, 16'h0003, 1'b1};
        vecs[8]  = '{1'b0, 2'd0, 16'h0000, 1'b1, 2'd1, 2'd3, 3'd2, 1'b1, 2'd1, 16'h0011, 1'b1, 16'h0011, 1'b0, 16'h0000, 1'b1};
        vecs[9]  = '{1'b0, 2'd0, 16'h0000, 1'b1, 2'd1, 2'd3, 3'd1, 1'b1, 2'd0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1};
        vecs[10] = '{1'b0, 2'd0, 16'h0000, 1'b1, 2'd1, 2'd3, 3'd0, 1'b0, 2'd0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1};

        // reset state
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("rst count",    32'(bus.count),     32'd0);
        check("rst empty",    32'(bus.empty),     32'd1);
        check("rst full",     32'(bus.full),      32'd0);
        check("rst in_ready", 32'(bus.in_ready),  32'd1);
        check("rst rf_write", 32'(bus.rf_write),  32'd0);
        check("rst rf_addr3", 32'(bus.rf_addr3),  32'd0);
        check("rst rf_data3", 32'(bus.rf_data3),  32'd0);
        check("rst fwd_hit1", 32'(bus.fwd_hit1),  32'd0);
        check("rst fwd_hit2", 32'(bus.fwd_hit2),  32'd0);
        check("rst fwd_data1", 32'(bus.fwd_data1), 32'd0);
        check("rst fwd_data2", 32'(bus.fwd_data2), 32'd0);

        // reset mid-stream with 3 entries queued, racing an enqueue and a drain
        tick();
        for (int k = 1; k <= 3; k++) begin
            bus.in_valid = 1'b1;
            bus.in_addr  = 2'(k);
            bus.in_data  = 16'(k * 16'h0101);
            tick();
        end
        bus.in_valid = 1'b0;
        #1;
        check("mid count before reset", 32'(bus.count), 32'd3);
        reset        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_addr  = 2'd3;
        bus.in_data  = 16'h0333;
        bus.drain_en = 1'b1;
        tick();
        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.fwd_addr1 = 2'd2;
        #1;
        check("mid count",    32'(bus.count),    32'd0);
        check("mid empty",    32'(bus.empty),    32'd1);
        check("mid rf_write", 32'(bus.rf_write), 32'd0);
        check("mid fwd_hit1", 32'(bus.fwd_hit1), 32'd0);
        tick();

        // one-cycle latency from accept to register-file write
        bus.drain_en = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_addr  = 2'd2;
        bus.in_data  = 16'hBEEF;
        #1;
        check("lat rf_write before accept", 32'(bus.rf_write), 32'd0);
        tick();
        bus.in_valid = 1'b0;
        #1;
        check("lat rf_write", 32'(bus.rf_write), 32'd1);
        check("lat rf_addr3", 32'(bus.rf_addr3), 32'd2);
        check("lat rf_data3", 32'(bus.rf_data3), 32'hBEEF);
        tick();
        #1;
        check("lat regfile r2", 32'(rf_model[2]), 32'hBEEF);
        check("lat empty",      32'(bus.empty),   32'd1);

        // table-driven fill to full then drain
        for (int i = 0; i < NV; i++) begin
            bus.in_valid  = vecs[i].v;
            bus.in_addr   = vecs[i].a;
            bus.in_data   = vecs[i].d;
            bus.drain_en  = vecs[i].dr;
            bus.fwd_addr1 = vecs[i].f1;
            bus.fwd_addr2 = vecs[i].f2;
            #1;
            check($sformatf("v%0d count", i),     32'(bus.count),     32'(vecs[i].cnt));
            check($sformatf("v%0d full", i),      32'(bus.full),      32'(vecs[i].cnt == 3'd4));
            check($sformatf("v%0d in_ready", i),  32'(bus.in_ready),  32'(vecs[i].rdy));
            check($sformatf("v%0d rf_write", i),  32'(bus.rf_write),  32'(vecs[i].rfw));
            check($sformatf("v%0d rf_addr3", i),  32'(bus.rf_addr3),  32'(vecs[i].rfa));
            check($sformatf("v%0d rf_data3", i),  32'(bus.rf_data3),  32'(vecs[i].rfd));
            check($sformatf("v%0d fwd_hit1", i),  32'(bus.fwd_hit1),  32'(vecs[i].h1));
            check($sformatf("v%0d fwd_data1", i), 32'(bus.fwd_data1), 32'(vecs[i].d1));
            check($sformatf("v%0d fwd_hit2", i),  32'(bus.fwd_hit2),  32'(vecs[i].h2));
            check($sformatf("v%0d fwd_data2", i), 32'(bus.fwd_data2), 32'(vecs[i].d2));
            tick();
        end
        bus.in_valid = 1'b0;
        bus.drain_en = 1'b0;
        #1;
        check("drain regfile r1", 32'(rf_model[1]), 32'h0011);
        check("drain regfile r3", 32'(rf_model[3]), 32'h0003);

        // two entries queued, then simultaneous enqueue/dequeue across pointer wrap
        for (int k = 0; k < 2; k++) begin
            bus.in_valid = 1'b1;
            bus.in_addr  = 2'(k);
            bus.in_data  = 16'(16'h1000 + k);
            tick();
        end
        for (int k = 0; k < 6; k++) begin
            bus.in_valid = 1'b1;
            bus.in_addr  = 2'(k + 2);
            bus.in_data  = 16'(16'h1002 + k);
            bus.drain_en = 1'b1;
            #1;
            check($sformatf("wrap%0d count", k),    32'(bus.count),    32'd2);
            check($sformatf("wrap%0d rf_write", k), 32'(bus.rf_write), 32'd1);
            check($sformatf("wrap%0d rf_data3", k), 32'(bus.rf_data3), 32'(16'h1000 + k));
            tick();
        end
        bus.in_valid = 1'b0;
        for (int k = 6; k < 8; k++) begin
            #1;
            check($sformatf("wrap tail%0d rf_data3", k), 32'(bus.rf_data3), 32'(16'h1000 + k));
            tick();
        end
        #1;
        check("wrap empty",       32'(bus.empty),   32'd1);
        check("wrap regfile r3",  32'(rf_model[3]), 32'h1007);

        // a write enqueued this edge is forwarded only from the next cycle
        bus.drain_en  = 1'b0;
        bus.fwd_addr1 = 2'd2;
        bus.in_valid  = 1'b1;
        bus.in_addr   = 2'd2;
        bus.in_data   = 16'hAAAA;
        #1;
        check("enq-fwd hit1 same cycle", 32'(bus.fwd_hit1), 32'd0);
        tick();
        bus.in_valid = 1'b0;
        #1;
        check("enq-fwd hit1 next cycle",  32'(bus.fwd_hit1),  32'd1);
        check("enq-fwd data1 next cycle", 32'(bus.fwd_data1), 32'hAAAA);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_write_queue.md
Name: rf_write_queue

Overview:
- Buffers register-write requests from execute and multi-cycle units.
- Drains one request per cycle into the 4x16 register file write port (write / addr3 / data3).
- Provides forwarding lookups on the two read addresses so consumers see pending values before they reach the register file.
- Sits between the writeback arbitration point and the register file; it is the writer end of the register-file write interface.

Parameters:
- DEPTH, 4, number of queue entries; power of two, at least 2.
- ADDR_W, 2, register address width.
- DATA_W, 16, register data width.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset, sampled on posedge clk.
- in_valid  input  1  write request present.
- in_ready  output  1  queue can accept a request this cycle.
- in_addr  input  ADDR_W  destination register.
- in_data  input  DATA_W  value to write.
- drain_en  input  1  register-file write port is available this cycle.
- rf_write  output  1  drives the register-file write enable.
- rf_addr3  output  ADDR_W  drives the register-file write address.
- rf_data3  output  DATA_W  drives the register-file write data.
- fwd_addr1  input  ADDR_W  read address 1, tied to the register-file addr1.
- fwd_addr2  input  ADDR_W  read address 2, tied to the register-file addr2.
- fwd_hit1  output  1  a pending write to fwd_addr1 exists.
- fwd_data1  output  DATA_W  newest pending value for fwd_addr1.
- fwd_hit2  output  1  a pending write to fwd_addr2 exists.
- fwd_data2  output  DATA_W  newest pending value for fwd_addr2.
- count  output  $clog2(DEPTH)+1  occupied entries.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.

Behaviour:
- Storage is a circular FIFO with head pointer, tail pointer and count.
  - Pointers wrap modulo DEPTH.
  - Entry storage holds addr and data only; validity is implied by position between head and tail.
- Reset (clk edge with reset=1):
  - head=0, tail=0, count=0.
  - All entries cleared to 0.
  - Resulting outputs: rf_write=0, rf_addr3=0, rf_data3=0, in_ready=1, empty=1, full=0, fwd_hit1=0, fwd_hit2=0, fwd_data1=0, fwd_data2=0.
  - Reset overrides any same-cycle enqueue or dequeue; requests in flight are discarded.
- Handshaking:
  - in_ready = !full, combinational from registered count. There is no same-cycle pass-through when full, even if a drain occurs.
  - Enqueue on an edge where in_valid && in_ready: entry[tail] <= {in_addr, in_data}, and tail advances.
  - in_addr / in_data are ignored when in_valid=0.
- Draining (register-file write):
  - rf_write = !empty && drain_en (combinational).
  - rf_addr3 / rf_data3 = entry[head] whenever !empty; 0 when empty.
  - Dequeue on an edge where rf_write=1; head advances. The register file captures the same values on the same edge.
- Latency:
  - A request accepted at edge N is at the head after edge N if the queue was empty.
  - It is written into the register file at edge N+1 when drain_en=1.
  - Minimum latency is 1 cycle; there is no combinational in-to-rf path.
- Simultaneous enqueue and dequeue: count is unchanged, and both pointers advance.
- Ordering: strict FIFO. Multiple pending writes to the same register are written in order; they are not coalesced.
- Forwarding (combinational):
  - For each lookup port, search the occupied entries head..tail-1.
  - A hit is an entry whose addr equals fwd_addrN. The newest matching entry (closest to tail) supplies fwd_dataN.
  - The head entry being drained in the current cycle still counts as a hit.
  - A request being enqueued in the current cycle is not visible until the next cycle.
  - No hit gives fwd_hitN=0 and fwd_dataN=0.
  - Consumers select fwd_dataN over the register-file dataN when fwd_hitN=1. This guarantees a read never observes a stale value.
- count, empty and full are derived from registered count and are glitch-free relative to clk.

Decomposition:
- Shared package rf_pkg:
  - constants RF_ADDR_W=2, RF_DATA_W=16, RF_NUM_REGS=4.
  - typedef rf_wr_req_t {addr, data}, used for queue entries and for the register-file write bundle.
- One sub-module, rf_fwd_match:
  - inputs: entry array, head, count, lookup address.
  - outputs: hit, data. Implements the newest-first priority search.
  - instantiated twice, once per read port.

Test Plan:
- Assert reset mid-stream with 3 entries queued:
  - next cycle count=0, empty=1, rf_write=0, fwd_hit1=0 with fwd_addr1 = one of the queued addresses.
- Empty queue, drain_en=1, enqueue {addr=2, data=16'hBEEF} at edge N:
  - rf_write=1, rf_addr3=2, rf_data3=16'hBEEF during cycle N+1.
  - Register file reads 16'hBEEF from r2 after edge N+1; empty=1.
- drain_en=0, enqueue {1,16'h0001}, {3,16'h0003}, {1,16'h0011}, {0,16'h0000}:
  - full=1, in_ready=0; a fifth in_valid is not accepted and count stays 4.
  - fwd_addr1=1 gives fwd_hit1=1 and fwd_data1=16'h0011.
  - fwd_addr2=2 gives fwd_hit2=0.
- From that full state, set drain_en=1 for 4 cycles:
  - rf_addr3/rf_data3 sequence is (1,0001), (3,0003), (1,0011), (0,0000).
  - fwd_hit1 for addr 1 stays 1 until the third dequeue edge.
- Queue holds 2 entries; enqueue and drain in the same cycle for 6 cycles with pointers wrapping past DEPTH-1:
  - count stays 2, and rf_data3 order matches issue order.
- Enqueue {2,16'hAAAA} on the same edge that fwd_addr1=2 is sampled:
  - fwd_hit1=0 that cycle and 1 the next cycle with 16'hAAAA.
